// File: rtl/pmc_pkg.sv
// Shared types and constants for the performance-monitor report path.
package pmc_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2,
    CHECKSUM = 2'd3
  } pmc_rpt_state_t;

  // Header + 16 payload bytes + checksum, for 32-bit counters
  localparam int unsigned PMC_FRAME_BYTES  = 18;
  localparam int unsigned PMC_NUM_COUNTERS = 4;

  // Order in which counters appear in the frame payload
  localparam int unsigned PMC_IDX_CYCLE = 0;
  localparam int unsigned PMC_IDX_STALL = 1;
  localparam int unsigned PMC_IDX_ARITH = 2;
  localparam int unsigned PMC_IDX_MEM   = 3;

endpackage

// File: rtl/pmc_trigger_timer.sv
// Free-running period timer merged with the external dump request.
// trig is high on a cycle where dump_req is set or the timer sits on its
// last count; PERIOD = 0 disables the periodic source entirely.
module pmc_trigger_timer
  import pmc_pkg::*;
#(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic dump_req,
  output logic trig
);

  localparam int unsigned TIMER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    (PERIOD > 1) ? TIMER_W'(PERIOD - 1) : '0;

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               wrap;

  // Next timer value and the merged trigger
  always_comb begin
    wrap    = (PERIOD != 0) && (timer_q == TIMER_LAST);
    timer_d = timer_q;
    if (PERIOD == 0) begin
      timer_d = '0;
    end else if (wrap) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    trig = dump_req | wrap;
  end

  // Timer register, runs regardless of the frame state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/pmc_report_unit.sv
// Snapshots the four PMC counters and streams them as a framed byte
// sequence (header, counters MSB-first, XOR checksum of the payload)
// over a valid/ready byte interface toward the debug UART.
module pmc_report_unit
  import pmc_pkg::*;
#(
  parameter int unsigned COUNT_W     = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int unsigned PERIOD      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dump_req,
  input  logic [COUNT_W-1:0] instr_cycle_count,
  input  logic [COUNT_W-1:0] stall_count,
  input  logic [COUNT_W-1:0] arith_count,
  input  logic [COUNT_W-1:0] mem_access_count,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned BYTES_PER_CNT = COUNT_W / 8;
  localparam int unsigned PAYLOAD_BYTES = PMC_NUM_COUNTERS * BYTES_PER_CNT;
  localparam int unsigned PAYLOAD_W     = PAYLOAD_BYTES * 8;
  localparam int unsigned IDX_W         = $clog2(PAYLOAD_BYTES);
  localparam int unsigned CNT_IDX_W     = $clog2(PMC_NUM_COUNTERS);

  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_IDX_W-1:0] I_CYC    = CNT_IDX_W'(PMC_IDX_CYCLE);
  localparam logic [CNT_IDX_W-1:0] I_STL    = CNT_IDX_W'(PMC_IDX_STALL);
  localparam logic [CNT_IDX_W-1:0] I_ARI    = CNT_IDX_W'(PMC_IDX_ARITH);
  localparam logic [CNT_IDX_W-1:0] I_MEM    = CNT_IDX_W'(PMC_IDX_MEM);

  pmc_rpt_state_t state_q;
  pmc_rpt_state_t state_d;
  logic           pending_q;
  logic           pending_d;
  logic [PMC_NUM_COUNTERS-1:0][COUNT_W-1:0] snap_q;
  logic [PMC_NUM_COUNTERS-1:0][COUNT_W-1:0] snap_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [7:0]       checksum_q;
  logic [7:0]       checksum_d;
  logic             tx_valid_q;
  logic             tx_valid_d;
  logic [7:0]       tx_data_q;
  logic [7:0]       tx_data_d;
  logic             frame_done_q;
  logic             frame_done_d;

  logic                 trig;
  logic                 xfer;
  logic [PAYLOAD_W-1:0] payload_flat;
  logic [PAYLOAD_W-1:0] payload_shift;
  logic [IDX_W-1:0]     sel_idx;
  logic [7:0]           sel_byte;

  pmc_trigger_timer #(
    .PERIOD (PERIOD)
  ) u_trigger_timer (
    .clk      (clk),
    .reset    (reset),
    .dump_req (dump_req),
    .trig     (trig)
  );

  // Payload byte that will be presented after the current transfer
  always_comb begin
    payload_flat  = {snap_q[I_CYC], snap_q[I_STL], snap_q[I_ARI], snap_q[I_MEM]};
    sel_idx       = (state_q == HEADER) ? '0 : idx_q + 1'b1;
    payload_shift = payload_flat >> (8 * (PAYLOAD_BYTES - 1 - 32'(sel_idx)));
    sel_byte      = payload_shift[7:0];
  end

  // Frame sequencer: next state, snapshot capture and output byte staging.
  // tx_data is registered and only advances on a transfer, which keeps it
  // stable under backpressure and keeps tx_valid independent of tx_ready.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    checksum_d   = checksum_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    xfer         = tx_valid_q & tx_ready;

    unique case (state_q)
      IDLE: begin
        if (trig || pending_q) begin
          state_d       = HEADER;
          snap_d[I_CYC] = instr_cycle_count;
          snap_d[I_STL] = stall_count;
          snap_d[I_ARI] = arith_count;
          snap_d[I_MEM] = mem_access_count;
          pending_d     = 1'b0;
          checksum_d    = '0;
          tx_valid_d    = 1'b1;
          tx_data_d     = HEADER_BYTE;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d   = PAYLOAD;
          idx_d     = '0;
          tx_data_d = sel_byte;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          checksum_d = checksum_q ^ tx_data_q;
          if (idx_q == IDX_LAST) begin
            state_d   = CHECKSUM;
            tx_data_d = checksum_q ^ tx_data_q;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = sel_byte;
          end
        end
      end
      CHECKSUM: begin
        if (xfer) begin
          state_d      = IDLE;
          tx_valid_d   = 1'b0;
          tx_data_d    = '0;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests arriving mid-frame (including on the checksum edge) queue one frame
    if (trig && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      snap_q       <= '0;
      idx_q        <= '0;
      checksum_q   <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      checksum_q   <= checksum_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output drive
  always_comb begin
    tx_valid   = tx_valid_q;
    tx_data    = tx_data_q;
    busy       = (state_q != IDLE);
    frame_done = frame_done_q;
  end

endmodule
